// File: rtl/ecap5_dproc_pkg.sv
// Shared ECAP5-DPROC definitions: load-store FSM states and byte-select encodings.
package ecap5_dproc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT_ACK
  } loadstore_state_t;

  localparam logic [3:0] LS_SEL_BYTE = 4'b0001;
  localparam logic [3:0] LS_SEL_HALF = 4'b0011;
  localparam logic [3:0] LS_SEL_WORD = 4'b1111;

endpackage

// File: rtl/loadstore_if.sv
// Wishbone B4 pipelined bus between the load-store stage (master) and memory (slave).
interface loadstore_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        wb_stall_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_stall_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_stall_i
  );
endinterface

// File: rtl/loadstore_ls_align.sv
// Combinational datapath: store lane shifting and load right-align plus extension.
// With LOADSTORE_MISALIGNED_CHECK_EN it also flags selects that spill past the word.
module ls_align
  import ecap5_dproc_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [3:0]  i_st_sel,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_sel,
  output logic [31:0] o_st_data,
`ifdef LOADSTORE_MISALIGNED_CHECK_EN
  output logic        o_misaligned,
`endif
  input  logic [1:0]  i_ld_off,
  input  logic [3:0]  i_ld_sel,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_sel_wide;
  logic [31:0] w_ld_shifted;
  logic        w_fill;

  // Widened so lanes pushed past byte 3 stay visible for the misalignment test.
  assign w_sel_wide = {4'b0000, i_st_sel} << i_st_off;
  assign o_st_sel   = w_sel_wide[3:0];
  assign o_st_data  = i_st_data << {i_st_off, 3'b000};

`ifdef LOADSTORE_MISALIGNED_CHECK_EN
  assign o_misaligned = |w_sel_wide[7:4];
`endif

  assign w_ld_shifted = i_ld_raw >> {i_ld_off, 3'b000};

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    o_ld_data = w_ld_shifted;
    w_fill    = 1'b0;
    case (i_ld_sel)
      LS_SEL_BYTE: begin
        w_fill    = ~i_ld_unsigned & w_ld_shifted[7];
        o_ld_data = {{24{w_fill}}, w_ld_shifted[7:0]};
      end
      LS_SEL_HALF: begin
        w_fill    = ~i_ld_unsigned & w_ld_shifted[15];
        o_ld_data = {{16{w_fill}}, w_ld_shifted[15:0]};
      end
      default: o_ld_data = w_ld_shifted;
    endcase
  end

endmodule

// File: rtl/loadstore.sv
// ECAP5-DPROC memory-access stage: one Wishbone transaction per load/store, registered write-back.
// Optional LOADSTORE_MISALIGNED_CHECK_EN adds ls_misaligned_o and suppresses misaligned bus cycles.
module loadstore
  import ecap5_dproc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        input_ready_o,
  input  logic        input_valid_i,
  input  logic [31:0] result_i,
  input  logic        ls_enable_i,
  input  logic        ls_write_i,
  input  logic [31:0] ls_write_data_i,
  input  logic [3:0]  ls_sel_i,
  input  logic        ls_unsigned_load_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  loadstore_if.master wb,
  output logic        output_valid_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o
`ifdef LOADSTORE_MISALIGNED_CHECK_EN
  ,
  output logic        ls_misaligned_o
`endif
);

  loadstore_state_t r_state;

  logic [31:0] r_wb_adr, r_wb_dat;
  logic [3:0]  r_wb_sel;
  logic        r_wb_we, r_wb_stb, r_wb_cyc;

  // Pending write-back info for the access in flight.
  logic [1:0]  r_off;
  logic [3:0]  r_sel;
  logic        r_unsigned;
  logic        r_pend_write;
  logic [4:0]  r_pend_addr;

  logic        r_valid, r_reg_write;
  logic [4:0]  r_reg_addr;
  logic [31:0] r_reg_data;

  logic        w_accept, w_done;
  logic [3:0]  w_st_sel;
  logic [31:0] w_st_data, w_ld_data;

`ifdef LOADSTORE_MISALIGNED_CHECK_EN
  logic        w_misaligned;
  logic        r_misaligned;
  assign ls_misaligned_o = r_misaligned;
`endif

  ls_align u_align (
    .i_st_off      (result_i[1:0]),
    .i_st_sel      (ls_sel_i),
    .i_st_data     (ls_write_data_i),
    .o_st_sel      (w_st_sel),
    .o_st_data     (w_st_data),
`ifdef LOADSTORE_MISALIGNED_CHECK_EN
    .o_misaligned  (w_misaligned),
`endif
    .i_ld_off      (r_off),
    .i_ld_sel      (r_sel),
    .i_ld_unsigned (r_unsigned),
    .i_ld_raw      (wb.wb_dat_i),
    .o_ld_data     (w_ld_data)
  );

  assign input_ready_o = (r_state == IDLE);
  assign w_accept      = input_valid_i && input_ready_o;
  // Ack with the first unstalled strobe completes without visiting WAIT_ACK.
  assign w_done = wb.wb_ack_i &&
                  ((r_state == WAIT_ACK) || (r_state == REQUEST && !wb.wb_stall_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_wb_adr     <= '0;
      r_wb_dat     <= '0;
      r_wb_sel     <= '0;
      r_wb_we      <= 1'b0;
      r_wb_stb     <= 1'b0;
      r_wb_cyc     <= 1'b0;
      r_off        <= '0;
      r_sel        <= '0;
      r_unsigned   <= 1'b0;
      r_pend_write <= 1'b0;
      r_pend_addr  <= '0;
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_data   <= '0;
`ifdef LOADSTORE_MISALIGNED_CHECK_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_valid <= 1'b0;
`ifdef LOADSTORE_MISALIGNED_CHECK_EN
      r_misaligned <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!ls_enable_i) begin
              r_reg_write <= reg_write_i;
              r_reg_addr  <= reg_addr_i;
              r_reg_data  <= result_i;
              r_valid     <= 1'b1;
            end
`ifdef LOADSTORE_MISALIGNED_CHECK_EN
            else if (w_misaligned) begin
              r_reg_write  <= 1'b0;
              r_reg_addr   <= reg_addr_i;
              r_reg_data   <= result_i;
              r_valid      <= 1'b1;
              r_misaligned <= 1'b1;
            end
`endif
            else begin
              r_wb_adr     <= {result_i[31:2], 2'b00};
              r_wb_dat     <= w_st_data;
              r_wb_sel     <= w_st_sel;
              r_wb_we      <= ls_write_i;
              r_wb_stb     <= 1'b1;
              r_wb_cyc     <= 1'b1;
              r_off        <= result_i[1:0];
              r_sel        <= ls_sel_i;
              r_unsigned   <= ls_unsigned_load_i;
              r_pend_write <= reg_write_i & ~ls_write_i;
              r_pend_addr  <= reg_addr_i;
              r_state      <= REQUEST;
            end
          end
        end
        REQUEST: begin
          if (!wb.wb_stall_i) begin
            r_wb_stb <= 1'b0;
            r_state  <= WAIT_ACK;
          end
        end
        WAIT_ACK: ;
        default: r_state <= IDLE;
      endcase

      if (w_done) begin
        r_wb_adr    <= '0;
        r_wb_dat    <= '0;
        r_wb_sel    <= '0;
        r_wb_we     <= 1'b0;
        r_wb_stb    <= 1'b0;
        r_wb_cyc    <= 1'b0;
        r_state     <= IDLE;
        r_valid     <= 1'b1;
        r_reg_write <= r_pend_write;
        r_reg_addr  <= r_pend_addr;
        if (!r_wb_we) r_reg_data <= w_ld_data;
      end
    end
  end

  assign wb.wb_adr_o = r_wb_adr;
  assign wb.wb_dat_o = r_wb_dat;
  assign wb.wb_sel_o = r_wb_sel;
  assign wb.wb_we_o  = r_wb_we;
  assign wb.wb_stb_o = r_wb_stb;
  assign wb.wb_cyc_o = r_wb_cyc;

  assign output_valid_o = r_valid;
  assign reg_write_o    = r_reg_write;
  assign reg_addr_o     = r_reg_addr;
  assign reg_data_o     = r_reg_data;

endmodule

// File: tb/tb_loadstore.sv
// Directed self-checking bench for loadstore; the bench acts as the Wishbone slave.
module tb_loadstore;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        input_ready_o;
  logic        input_valid_i = 1'b0;
  logic [31:0] result_i = '0;
  logic        ls_enable_i = 1'b0;
  logic        ls_write_i = 1'b0;
  logic [31:0] ls_write_data_i = '0;
  logic [3:0]  ls_sel_i = '0;
  logic        ls_unsigned_load_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [4:0]  reg_addr_i = '0;
  logic        output_valid_o;
  logic        reg_write_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_o;
`ifdef LOADSTORE_MISALIGNED_CHECK_EN
  logic        ls_misaligned_o;
`endif

  loadstore_if wb ();

  loadstore dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .input_ready_o      (input_ready_o),
    .input_valid_i      (input_valid_i),
    .result_i           (result_i),
    .ls_enable_i        (ls_enable_i),
    .ls_write_i         (ls_write_i),
    .ls_write_data_i    (ls_write_data_i),
    .ls_sel_i           (ls_sel_i),
    .ls_unsigned_load_i (ls_unsigned_load_i),
    .reg_write_i        (reg_write_i),
    .reg_addr_i         (reg_addr_i),
    .wb                 (wb),
    .output_valid_o     (output_valid_o),
    .reg_write_o        (reg_write_o),
    .reg_addr_o         (reg_addr_o),
    .reg_data_o         (reg_data_o)
`ifdef LOADSTORE_MISALIGNED_CHECK_EN
    ,
    .ls_misaligned_o    (ls_misaligned_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic en, input logic wr, input logic [31:0] res,
                       input logic [31:0] data, input logic [3:0] sel,
                       input logic uns, input logic rw, input logic [4:0] ra);
    input_valid_i      = 1'b1;
    ls_enable_i        = en;
    ls_write_i         = wr;
    result_i           = res;
    ls_write_data_i    = data;
    ls_sel_i           = sel;
    ls_unsigned_load_i = uns;
    reg_write_i        = rw;
    reg_addr_i         = ra;
  endtask

  int stb_cnt, v_cnt, v_cyc;
  logic [31:0] v_data;

  initial begin
    wb.wb_dat_i   = '0;
    wb.wb_ack_i   = 1'b0;
    wb.wb_stall_i = 1'b0;

    // Reset state
    #12;
    check("rst_ready", input_ready_o, 1);
    check("rst_cyc", wb.wb_cyc_o, 0);
    check("rst_stb", wb.wb_stb_o, 0);
    check("rst_valid", output_valid_o, 0);
    check("rst_adr", wb.wb_adr_o, 0);
    check("rst_data", reg_data_o, 0);
    #5 rst_i = 1'b1;
    tick();

    // Non-memory pass-through
    drive(0, 0, 32'h1234_5678, 0, 4'b0000, 0, 1, 5);
    tick();
    input_valid_i = 1'b0;
    check("nm_valid", output_valid_o, 1);
    check("nm_data", reg_data_o, 32'h1234_5678);
    check("nm_addr", reg_addr_o, 5);
    check("nm_wr", reg_write_o, 1);
    check("nm_cyc", wb.wb_cyc_o, 0);
    tick();
    check("nm_pulse", output_valid_o, 0);

    // Back-to-back non-memory
    drive(0, 0, 32'hA5A5_0001, 0, 4'b0000, 0, 1, 1);
    tick();
    check("b2b_v0", output_valid_o, 1);
    check("b2b_d0", reg_data_o, 32'hA5A5_0001);
    check("b2b_rdy", input_ready_o, 1);
    drive(0, 0, 32'h5A5A_0002, 0, 4'b0000, 0, 0, 2);
    tick();
    input_valid_i = 1'b0;
    check("b2b_v1", output_valid_o, 1);
    check("b2b_d1", reg_data_o, 32'h5A5A_0002);
    check("b2b_wr1", reg_write_o, 0);
    tick();
    check("b2b_end", output_valid_o, 0);

    // Byte store at offset 3, ack one cycle after strobe
    drive(1, 1, 32'h0000_1003, 32'h0000_00AB, 4'b0001, 0, 1, 9);
    tick();
    input_valid_i = 1'b0;
    check("st_cyc", wb.wb_cyc_o, 1);
    check("st_stb", wb.wb_stb_o, 1);
    check("st_adr", wb.wb_adr_o, 32'h0000_1000);
    check("st_sel", wb.wb_sel_o, 4'b1000);
    check("st_dat", wb.wb_dat_o, 32'hAB00_0000);
    check("st_we", wb.wb_we_o, 1);
    check("st_rdy", input_ready_o, 0);
    tick();
    check("st_stb_drop", wb.wb_stb_o, 0);
    check("st_cyc_hold", wb.wb_cyc_o, 1);
    check("st_novalid", output_valid_o, 0);
    wb.wb_ack_i = 1'b1;
    tick();
    wb.wb_ack_i = 1'b0;
    check("st_valid", output_valid_o, 1);
    check("st_wr_forced", reg_write_o, 0);
    check("st_cyc_done", wb.wb_cyc_o, 0);
    check("st_adr_idle", wb.wb_adr_o, 0);
    check("st_rdy_done", input_ready_o, 1);
    tick();
    check("st_pulse", output_valid_o, 0);

    // Signed half load at offset 2, ack with the first unstalled strobe (2-cycle latency)
    drive(1, 0, 32'h0000_2002, 0, 4'b0011, 0, 1, 7);
    tick();
    input_valid_i = 1'b0;
    check("lh_sel", wb.wb_sel_o, 4'b1100);
    check("lh_adr", wb.wb_adr_o, 32'h0000_2000);
    check("lh_we", wb.wb_we_o, 0);
    wb.wb_ack_i = 1'b1;
    wb.wb_dat_i = 32'h8001_0000;
    tick();
    wb.wb_ack_i = 1'b0;
    check("lh_valid", output_valid_o, 1);
    check("lh_data", reg_data_o, 32'hFFFF_8001);
    check("lh_addr", reg_addr_o, 7);
    check("lh_wr", reg_write_o, 1);

    // Unsigned half load, ack one cycle after strobe
    drive(1, 0, 32'h0000_2002, 0, 4'b0011, 1, 1, 8);
    tick();
    input_valid_i = 1'b0;
    tick();
    wb.wb_ack_i = 1'b1;
    tick();
    wb.wb_ack_i = 1'b0;
    check("lhu_valid", output_valid_o, 1);
    check("lhu_data", reg_data_o, 32'h0000_8001);

    // Signed byte load at offset 1
    drive(1, 0, 32'h0000_0011, 0, 4'b0001, 0, 1, 4);
    tick();
    input_valid_i = 1'b0;
    check("lb_sel", wb.wb_sel_o, 4'b0010);
    wb.wb_ack_i = 1'b1;
    wb.wb_dat_i = 32'h0000_F000;
    tick();
    wb.wb_ack_i = 1'b0;
    check("lb_data", reg_data_o, 32'hFFFF_FFF0);

    // Word load: 3 stall cycles, then ack two cycles after the strobe is taken
    wb.wb_stall_i = 1'b1;
    wb.wb_dat_i   = 32'hCAFE_F00D;
    drive(1, 0, 32'h0000_0040, 0, 4'b1111, 0, 1, 3);
    tick();
    input_valid_i = 1'b0;
    stb_cnt = 0;
    v_cnt   = 0;
    v_cyc   = 0;
    v_data  = '0;
    for (int c = 1; c <= 10; c++) begin
      if (wb.wb_stb_o) stb_cnt++;
      if (output_valid_o) begin
        v_cnt++;
        v_cyc  = c;
        v_data = reg_data_o;
      end
      wb.wb_stall_i = (c <= 3);
      wb.wb_ack_i   = (c == 6);
      tick();
    end
    wb.wb_ack_i   = 1'b0;
    wb.wb_stall_i = 1'b0;
    check("stall_stb_cycles", stb_cnt, 4);
    check("stall_valid_count", v_cnt, 1);
    check("stall_valid_cycle", v_cyc, 7);
    check("stall_data", v_data, 32'hCAFE_F00D);

    // Reset asserted while waiting for ack
    drive(1, 0, 32'h0000_0080, 0, 4'b1111, 0, 1, 6);
    tick();
    input_valid_i = 1'b0;
    tick();
    check("rmid_cyc_before", wb.wb_cyc_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check("rmid_cyc_async", wb.wb_cyc_o, 0);
    check("rmid_stb_async", wb.wb_stb_o, 0);
    #2 rst_i = 1'b1;
    wb.wb_ack_i = 1'b1;
    v_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      wb.wb_ack_i = 1'b0;
      if (output_valid_o) v_cnt++;
    end
    check("rmid_no_valid", v_cnt, 0);
    check("rmid_rdy", input_ready_o, 1);
    check("idle_ack_cyc", wb.wb_cyc_o, 0);

`ifdef LOADSTORE_MISALIGNED_CHECK_EN
    // Misaligned word at offset 2
    drive(1, 0, 32'h0000_0002, 0, 4'b1111, 0, 1, 10);
    tick();
    input_valid_i = 1'b0;
    check("mis_cyc", wb.wb_cyc_o, 0);
    check("mis_valid", output_valid_o, 1);
    check("mis_flag", ls_misaligned_o, 1);
    check("mis_wr", reg_write_o, 0);
    tick();
    check("mis_flag_pulse", ls_misaligned_o, 0);
    check("mis_cyc_after", wb.wb_cyc_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/loadstore.md
# loadstore

Memory-access stage of the ECAP5-DPROC pipeline, sitting directly after `execute`. It consumes the execute stage's load-store and write-back pass-through outputs over a ready/valid handshake. For loads and stores it runs one Wishbone B4 pipelined master transaction, aligning store data and extending load data. It then presents a single registered write-back record to the register-file stage.

## Interface
Parameters:
- none.

Ports:
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `input_ready_o` out 1: stage can accept a new instruction.
- `input_valid_i` in 1: upstream record valid.
- `result_i` in 32: ALU result; the byte address for memory ops.
- `ls_enable_i` in 1: instruction accesses memory.
- `ls_write_i` in 1: 1 = store, 0 = load.
- `ls_write_data_i` in 32: store data, right-aligned.
- `ls_sel_i` in 4: unshifted byte mask; 0001 = byte, 0011 = half, 1111 = word.
- `ls_unsigned_load_i` in 1: zero-extend (1) or sign-extend (0) load data.
- `reg_write_i` in 1: write-back enable, passed through.
- `reg_addr_i` in 5: destination register.
- `wb_adr_o` out 32: word address; bits [1:0] are 0.
- `wb_dat_o` out 32: shifted store data.
- `wb_dat_i` in 32: read data.
- `wb_sel_o` out 4: shifted byte select.
- `wb_we_o` out 1: write enable.
- `wb_stb_o` out 1: strobe.
- `wb_cyc_o` out 1: cycle.
- `wb_ack_i` in 1: acknowledge.
- `wb_stall_i` in 1: slave stall.
- `output_valid_o` out 1: one-cycle pulse, write-back record valid.
- `reg_write_o` out 1: write-back enable.
- `reg_addr_o` out 5: destination register.
- `reg_data_o` out 32: write-back data.
- `ls_misaligned_o` out 1: misalignment flag, present only with the macro described under Configuration.

## Operation
- FSM states: IDLE, REQUEST, WAIT_ACK.
- `input_ready_o` = 1 only in IDLE.
- Accept = `input_valid_i && input_ready_o`.

IDLE:
- On accept with `ls_enable_i = 0`: register `reg_write_i`, `reg_addr_i` and `reg_data = result_i`; pulse `output_valid_o`; stay in IDLE.
- On accept with `ls_enable_i = 1`: latch all inputs, drive the bus, go to REQUEST.

Bus drive for a memory access:
- `wb_adr_o = {result_i[31:2], 2'b00}`.
- `off = result_i[1:0]`.
- `wb_sel_o = ls_sel_i << off`.
- `wb_dat_o = ls_write_data_i << (8*off)`.
- `wb_we_o = ls_write_i`.
- `wb_cyc_o = 1`, `wb_stb_o = 1`.

REQUEST:
- Hold all bus outputs while `wb_stall_i = 1`.
- When stall is low, drop `wb_stb_o` on the next edge and go to WAIT_ACK.
- If `wb_ack_i` arrives in the same cycle stall is low, complete directly.

WAIT_ACK:
- `wb_cyc_o` stays high until `wb_ack_i`.
- On ack: drop `wb_cyc_o`, return to IDLE, pulse `output_valid_o`.

Completion data:
- Load: `raw = wb_dat_i >> (8*off)`. Byte loads extend bit 7, half-word loads extend bit 15; extension is sign or zero per `ls_unsigned_load`. Word loads pass through.
- Store: `reg_write_o` is forced to 0.

General rules:
- Only one transaction is outstanding at a time.
- `wb_ack_i` in IDLE is ignored.
- Idle bus outputs are 0.

## Timing
- Reset values: all outputs 0 except `input_ready_o = 1`; FSM in IDLE.
- Reset assertion mid-transaction drops `wb_cyc_o` and `wb_stb_o` immediately (asynchronous) and discards the record.
- Non-memory instruction: accepted in cycle 0; `output_valid_o` high in cycle 1.
- Memory op with zero stall and ack one cycle after strobe:
  - accept in cycle 0;
  - `wb_stb_o` high in cycle 1;
  - ack in cycle 2;
  - `output_valid_o` in cycle 3.
- Minimum memory latency is 2 cycles, when ack arrives with the first unstalled strobe.
- Each stall cycle or ack wait cycle adds one cycle of latency.
- `output_valid_o` is high for exactly one cycle per accepted instruction.
- Back-to-back non-memory instructions sustain one per cycle.
- No new accept is possible until the cycle after ack.

## Configuration
Macro: `LOADSTORE_MISALIGNED_CHECK_EN`.
- Defined:
  - An access is misaligned when `(ls_sel_i << off)` overflows 4 bits: a half-word at off = 3, or a word at off ≠ 0.
  - No bus cycle is issued for a misaligned access.
  - The cycle after accept, `output_valid_o` = 1, `ls_misaligned_o` = 1 and `reg_write_o` = 0.
- Undefined:
  - The `ls_misaligned_o` port is absent.
  - Overflowing `wb_sel_o` bits are truncated and the access is issued as-is.

## Structure
- `ecap5_dproc_pkg` gains:
  - the FSM state enum `loadstore_state_t` (IDLE, REQUEST, WAIT_ACK);
  - the constants `LS_SEL_BYTE = 4'b0001`, `LS_SEL_HALF = 4'b0011`, `LS_SEL_WORD = 4'b1111`.
- One combinational sub-module, `ls_align`, performs store shift/select generation and load shift/extension. This keeps the FSM file free of datapath muxing.

## Test plan
- Non-memory pass-through: `result_i = 0x1234_5678`, `reg_addr_i = 5`, `reg_write_i = 1` → cycle 1: `output_valid_o = 1`, `reg_data_o = 0x1234_5678`, no `wb_cyc_o`.
- Byte store: address `0x0000_1003`, data `0x0000_00AB`, sel 0001 → `wb_adr_o = 0x1000`, `wb_sel_o = 1000`, `wb_dat_o = 0xAB00_0000`, `wb_we_o = 1`, `reg_write_o = 0` on completion.
- Signed half load: address `0x2002`, `wb_dat_i = 0x8001_0000` → `reg_data_o = 0xFFFF_8001`. Same access with `ls_unsigned_load_i = 1` → `0x0000_8001`.
- Stall and ack delay: `wb_stall_i` high for 3 cycles, ack 2 cycles later → `wb_stb_o` high 4 cycles, `output_valid_o` in cycle 7, exactly one pulse.
- Reset mid-transaction: assert `rst_i` low in WAIT_ACK → `wb_cyc_o` = 0 within the same cycle; no `output_valid_o` after release.
- Misaligned word at `0x0000_0002` with `LOADSTORE_MISALIGNED_CHECK_EN` → no `wb_cyc_o`, cycle 1: `ls_misaligned_o = 1`, `reg_write_o = 0`.
